ttt_game_controller: RTL and testbench
======================================

Name: ttt_game_controller

Overview:
- Turn sequencer and arbiter for the tic-tac-toe board.
- Two move sources share one 3x3 board: the switch front-end for player X and the UART receive front-end for player O.
- Accepts only the active player's move, validates it, and commits it to board registers.
- Detects win and draw, and exposes board/status to the 7-segment and LED drivers in top_level.

Parameters:
FIRST_PLAYER, 0, starting player after reset (0 = X, 1 = O).
ALTERNATE_START, 1, when 1 each new_game gives the first move to the player who did not start the previous game.

Ports:
clk  in  1  system clock (100 MHz).
reset  in  1  asynchronous, active-low reset.
sw_move_valid  in  1  one-cycle pulse: X move request.
sw_move_cell  in  4  X target cell, 0..8; cell i is row i/3, col i%3.
uart_move_valid  in  1  one-cycle pulse: O move request.
uart_move_cell  in  4  O target cell, 0..8.
new_game  in  1  one-cycle pulse: clear board and restart.
board_x  out  9  bit i set = X occupies cell i.
board_o  out  9  bit i set = O occupies cell i.
turn_o  out  1  0 = X to move, 1 = O to move.
game_state  out  2  00 PLAY, 01 CHECK, 10 DONE.
winner  out  2  00 none, 01 X, 10 O, 11 draw.
win_line  out  9  cell mask of the winning line; 0 if no win.
move_count  out  4  committed moves, 0..9.
reject_code  out  2  one-cycle pulse: 00 none, 01 wrong turn/busy, 10 cell out of range, 11 cell occupied.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - board_x = board_o = 0, move_count = 0, winner = 00, win_line = 0, reject_code = 00.
  - game_state = PLAY, turn_o = FIRST_PLAYER.
  - Internal start-player register = FIRST_PLAYER.
- PLAY:
  - Active source is sw when turn_o = 0, uart when turn_o = 1.
  - If the active valid is asserted, the cell is checked:
    - cell > 8 -> reject 10.
    - cell already set in board_x | board_o -> reject 11.
    - otherwise set the cell bit in the active player's board next edge, move_count += 1, game_state -> CHECK.
  - Inactive-source valid while the active valid is also asserted: dropped silently; reject_code reflects the active source only.
  - Inactive-source valid alone: reject 01, no state change.
- CHECK (exactly one cycle):
  - win_detect runs on the registered boards.
  - Mover has a line -> winner = mover, win_line = that line's mask, DONE.
  - Else move_count = 9 -> winner = 11, DONE.
  - Else toggle turn_o, back to PLAY.
  - A win on the ninth move reports the win, not a draw.
  - Any move valid in CHECK -> reject 01, dropped.
- DONE:
  - Board, winner and win_line are held.
  - Any move valid -> reject 01.
- new_game (any state) has priority over a move in the same cycle:
  - Next edge: boards = 0, move_count = 0, winner = 00, win_line = 0, game_state = PLAY, reject_code = 00.
  - If ALTERNATE_START = 1, invert the start-player register; turn_o = new start player.
  - Otherwise turn_o = start player (unchanged).
- Latency:
  - Valid at edge N -> board bit visible after edge N+1.
  - winner, game_state DONE, or turn toggle visible after edge N+2.
  - reject_code visible after edge N+1 for one cycle.
- Multiple winning lines on one move: report the lowest-index line in the WIN_LINES table.
- Reset mid-game: immediate return to reset values, no partial commit.

Decomposition:
- Package ttt_pkg:
  - cell_t (logic [3:0]).
  - game_state_e, winner_e, reject_e enums.
  - NUM_CELLS = 9.
  - WIN_LINES: 8 x 9-bit masks, ordered rows 0-2, cols 0-2, diag 0-4-8, anti-diag 2-4-6. Row 0 = 9'h007.
- Sub-module ttt_win_detect: purely combinational; board[8:0] -> win flag and line mask. Shared later by any AI-move block.

Test Plan:
1. Assert reset low mid-sequence, release -> all outputs at reset values, game_state = PLAY, turn_o = 0 (FIRST_PLAYER = 0).
2. Row win sequence X0, O3, X1, O4, X2 -> board_x = 9'h007, board_o = 9'h018, winner = 01, win_line = 9'h007, DONE two cycles after the last pulse. A further sw pulse -> reject 01.
3. Occupied cell: X4 then O4 -> reject 11, board_o = 0, turn_o stays 1. Then O0 is accepted.
4. Bad requests on X's turn:
   - uart_move_valid alone -> reject 01.
   - sw cell 9 -> reject 10.
   - sw cell 5 together with uart cell 6 -> X5 committed, no reject.
5. Draw sequence X0, O1, X2, O4, X3, O5, X7, O6, X8 -> board_x = 9'h18D, board_o = 9'h072, winner = 11, win_line = 0, move_count = 9.
6. new_game pulsed together with sw move in DONE -> move ignored, boards cleared, turn_o = 1 (ALTERNATE_START = 1). Second new_game -> turn_o = 0.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe controller and its helpers.
// Cell i of the 3x3 board is row i/3, column i%3.
package ttt_pkg;

  localparam int unsigned NUM_CELLS = 9;

  typedef logic [3:0] cell_t;

  typedef enum logic [1:0] {
    GS_PLAY  = 2'b00,
    GS_CHECK = 2'b01,
    GS_DONE  = 2'b10
  } game_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_X    = 2'b01,
    WIN_O    = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  typedef enum logic [1:0] {
    REJ_NONE     = 2'b00,
    REJ_BUSY     = 2'b01,
    REJ_RANGE    = 2'b10,
    REJ_OCCUPIED = 2'b11
  } reject_e;

  // Rows 0-2, columns 0-2, main diagonal, anti-diagonal; lower index wins ties.
  localparam logic [8:0] WIN_LINES [8] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  // One-hot mask for a cell; out-of-range cells give an empty mask.
  function automatic logic [8:0] cell_mask(input cell_t c);
    return (c < 4'(NUM_CELLS)) ? (9'd1 << c) : '0;
  endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational three-in-a-row detector for one player's board.
// Reports the lowest-index completed line from WIN_LINES.
module ttt_win_detect
  import ttt_pkg::*;
(
  input  logic [8:0] board,
  output logic       win,
  output logic [8:0] win_line
);

  always_comb begin
    win      = 1'b0;
    win_line = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!win && ((board & WIN_LINES[i]) == WIN_LINES[i])) begin
        win      = 1'b1;
        win_line = WIN_LINES[i];
      end
    end
  end

endmodule

// File: rtl/ttt_game_controller.sv
// Turn sequencer/arbiter: accepts the active player's move, commits it,
// then spends one CHECK cycle deciding win, draw or turn hand-over.
module ttt_game_controller
  import ttt_pkg::*;
#(
  parameter logic FIRST_PLAYER    = 1'b0,
  parameter logic ALTERNATE_START = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_move_valid,
  input  logic [3:0] sw_move_cell,
  input  logic       uart_move_valid,
  input  logic [3:0] uart_move_cell,
  input  logic       new_game,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       turn_o,
  output logic [1:0] game_state,
  output logic [1:0] winner,
  output logic [8:0] win_line,
  output logic [3:0] move_count,
  output logic [1:0] reject_code
);

  game_state_e state_q, state_d;
  winner_e     winner_q, winner_d;
  reject_e     reject_q, reject_d;
  logic [8:0]  bx_q, bx_d, bo_q, bo_d, line_q, line_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        turn_q, turn_d, start_q, start_d;

  logic        active_valid, inactive_valid, any_valid;
  cell_t       active_cell;
  logic [8:0]  active_mask;
  logic        det_win;
  logic [8:0]  det_line;

  // The mover's board is examined; turn only flips after CHECK.
  ttt_win_detect u_win_detect (
    .board    (turn_q ? bo_q : bx_q),
    .win      (det_win),
    .win_line (det_line)
  );

  assign active_valid   = turn_q ? uart_move_valid : sw_move_valid;
  assign inactive_valid = turn_q ? sw_move_valid : uart_move_valid;
  assign active_cell    = turn_q ? uart_move_cell : sw_move_cell;
  assign any_valid      = sw_move_valid | uart_move_valid;
  assign active_mask    = cell_mask(active_cell);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= GS_PLAY;
      winner_q <= WIN_NONE;
      reject_q <= REJ_NONE;
      bx_q     <= '0;
      bo_q     <= '0;
      line_q   <= '0;
      cnt_q    <= '0;
      turn_q   <= FIRST_PLAYER;
      start_q  <= FIRST_PLAYER;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      reject_q <= reject_d;
      bx_q     <= bx_d;
      bo_q     <= bo_d;
      line_q   <= line_d;
      cnt_q    <= cnt_d;
      turn_q   <= turn_d;
      start_q  <= start_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    reject_d = REJ_NONE;
    bx_d     = bx_q;
    bo_d     = bo_q;
    line_d   = line_q;
    cnt_d    = cnt_q;
    turn_d   = turn_q;
    start_d  = start_q;

    if (new_game) begin
      state_d  = GS_PLAY;
      winner_d = WIN_NONE;
      bx_d     = '0;
      bo_d     = '0;
      line_d   = '0;
      cnt_d    = '0;
      start_d  = ALTERNATE_START ? ~start_q : start_q;
      turn_d   = start_d;
    end else begin
      case (state_q)
        GS_PLAY: begin
          if (active_valid) begin
            if (active_cell >= 4'(NUM_CELLS)) begin
              reject_d = REJ_RANGE;
            end else if (|((bx_q | bo_q) & active_mask)) begin
              reject_d = REJ_OCCUPIED;
            end else begin
              if (turn_q) bo_d = bo_q | active_mask;
              else        bx_d = bx_q | active_mask;
              cnt_d   = cnt_q + 4'd1;
              state_d = GS_CHECK;
            end
          end else if (inactive_valid) begin
            reject_d = REJ_BUSY;
          end
        end
        GS_CHECK: begin
          if (any_valid) reject_d = REJ_BUSY;
          if (det_win) begin
            winner_d = turn_q ? WIN_O : WIN_X;
            line_d   = det_line;
            state_d  = GS_DONE;
          end else if (cnt_q == 4'(NUM_CELLS)) begin
            winner_d = WIN_DRAW;
            state_d  = GS_DONE;
          end else begin
            turn_d  = ~turn_q;
            state_d = GS_PLAY;
          end
        end
        GS_DONE: begin
          if (any_valid) reject_d = REJ_BUSY;
        end
        default: state_d = GS_PLAY;
      endcase
    end
  end

  assign board_x     = bx_q;
  assign board_o     = bo_q;
  assign turn_o      = turn_q;
  assign game_state  = state_q;
  assign winner      = winner_q;
  assign win_line    = line_q;
  assign move_count  = cnt_q;
  assign reject_code = reject_q;

endmodule

// File: tb/tb_ttt_game_controller.sv
// Scoreboard bench for ttt_game_controller: each request queues the outputs
// it should produce at a given cycle; a negedge monitor retires them.
module tb_ttt_game_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sw_move_valid = 1'b0;
  logic [3:0] sw_move_cell = '0;
  logic       uart_move_valid = 1'b0;
  logic [3:0] uart_move_cell = '0;
  logic       new_game = 1'b0;
  logic [8:0] board_x, board_o, win_line;
  logic       turn_o;
  logic [1:0] game_state, winner, reject_code;
  logic [3:0] move_count;

  always #5 clk = ~clk;

  ttt_game_controller #(
    .FIRST_PLAYER    (1'b0),
    .ALTERNATE_START (1'b1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sw_move_valid   (sw_move_valid),
    .sw_move_cell    (sw_move_cell),
    .uart_move_valid (uart_move_valid),
    .uart_move_cell  (uart_move_cell),
    .new_game        (new_game),
    .board_x         (board_x),
    .board_o         (board_o),
    .turn_o          (turn_o),
    .game_state      (game_state),
    .winner          (winner),
    .win_line        (win_line),
    .move_count      (move_count),
    .reject_code     (reject_code)
  );

  typedef enum int {S_BX, S_BO, S_TURN, S_STATE, S_WIN, S_LINE, S_CNT, S_REJ} sig_e;
  typedef struct {
    int unsigned due;
    sig_e        sig;
    logic [8:0]  val;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model of the game, advanced as stimulus is issued.
  bit          mturn, mstart;
  logic [8:0]  mx, mo, mline;
  logic [1:0]  mwin;
  int          mcnt, mstate;
  logic [8:0]  lines [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] observe(input sig_e s);
    case (s)
      S_BX:    return board_x;
      S_BO:    return board_o;
      S_TURN:  return 9'(turn_o);
      S_STATE: return 9'(game_state);
      S_WIN:   return 9'(winner);
      S_LINE:  return win_line;
      S_CNT:   return 9'(move_count);
      default: return 9'(reject_code);
    endcase
  endfunction

  function automatic logic [8:0] model_line(input logic [8:0] b);
    for (int i = 0; i < 8; i++)
      if ((b & lines[i]) == lines[i]) return lines[i];
    return '0;
  endfunction

  task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input string tag, input sig_e s, input logic [8:0] v, input int unsigned d);
    exp_t e;
    e.due = cyc + d;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t keep[$];
    keep = {};
    foreach (exp_q[i]) begin
      if (exp_q[i].due == cyc) check_val(exp_q[i].tag, observe(exp_q[i].sig), exp_q[i].val);
      else keep.push_back(exp_q[i]);
    end
    exp_q = keep;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mturn = 1'b0; mstart = 1'b0; mx = '0; mo = '0;
    mcnt = 0; mstate = 0; mwin = 2'b00; mline = '0;
  endtask

  task automatic push_reset_vals(input int unsigned d);
    push_exp("rst_bx", S_BX, '0, d);
    push_exp("rst_bo", S_BO, '0, d);
    push_exp("rst_turn", S_TURN, '0, d);
    push_exp("rst_state", S_STATE, '0, d);
    push_exp("rst_winner", S_WIN, '0, d);
    push_exp("rst_line", S_LINE, '0, d);
    push_exp("rst_count", S_CNT, '0, d);
    push_exp("rst_reject", S_REJ, '0, d);
  endtask

  // One request cycle; busy_next fires a second pulse during the CHECK cycle.
  task automatic do_req(input bit sv, input logic [3:0] sc, input bit uv, input logic [3:0] uc,
                        input logic [1:0] erej, input bit busy_next);
    bit         act_v;
    logic [3:0] act_c;
    logic [8:0] ln;
    sw_move_valid = sv; sw_move_cell = sc;
    uart_move_valid = uv; uart_move_cell = uc;
    push_exp("reject", S_REJ, 9'(erej), 1);
    act_v = mturn ? uv : sv;
    act_c = mturn ? uc : sc;
    if (mstate == 0 && act_v && erej == 2'b00) begin
      if (mturn) mo[act_c] = 1'b1;
      else       mx[act_c] = 1'b1;
      mcnt++;
      push_exp("commit_bx", S_BX, mx, 1);
      push_exp("commit_bo", S_BO, mo, 1);
      push_exp("commit_count", S_CNT, 9'(mcnt), 1);
      push_exp("commit_state", S_STATE, 9'd1, 1);
      push_exp("hold_bx", S_BX, mx, 2);
      push_exp("hold_bo", S_BO, mo, 2);
      ln = model_line(mturn ? mo : mx);
      if (ln != '0) begin
        mwin = mturn ? 2'b10 : 2'b01; mline = ln; mstate = 2;
      end else if (mcnt == 9) begin
        mwin = 2'b11; mline = '0; mstate = 2;
      end else begin
        mturn = ~mturn; mstate = 0;
      end
      push_exp("after_winner", S_WIN, 9'(mwin), 2);
      push_exp("after_line", S_LINE, mline, 2);
      push_exp("after_state", S_STATE, 9'(mstate), 2);
      push_exp("after_turn", S_TURN, 9'(mturn), 2);
    end else begin
      push_exp("nochg_bx", S_BX, mx, 1);
      push_exp("nochg_bo", S_BO, mo, 1);
      push_exp("nochg_turn", S_TURN, 9'(mturn), 1);
      push_exp("nochg_state", S_STATE, 9'(mstate), 1);
      push_exp("nochg_winner", S_WIN, 9'(mwin), 1);
    end
    tick();
    sw_move_valid = 1'b0; uart_move_valid = 1'b0;
    if (busy_next) begin
      sw_move_valid = 1'b1; sw_move_cell = 4'd8;
      uart_move_valid = 1'b1; uart_move_cell = 4'd8;
      push_exp("check_busy", S_REJ, 9'd1, 1);
      tick();
      sw_move_valid = 1'b0; uart_move_valid = 1'b0;
    end else begin
      push_exp("reject_pulse", S_REJ, '0, 1);
      tick();
    end
  endtask

  task automatic do_new_game(input bit with_move);
    new_game = 1'b1;
    if (with_move) begin
      sw_move_valid = 1'b1; sw_move_cell = 4'd8;
    end
    mstart = ~mstart; mturn = mstart;
    mx = '0; mo = '0; mcnt = 0; mstate = 0; mwin = 2'b00; mline = '0;
    push_exp("ng_bx", S_BX, '0, 1);
    push_exp("ng_bo", S_BO, '0, 1);
    push_exp("ng_count", S_CNT, '0, 1);
    push_exp("ng_winner", S_WIN, '0, 1);
    push_exp("ng_line", S_LINE, '0, 1);
    push_exp("ng_state", S_STATE, '0, 1);
    push_exp("ng_reject", S_REJ, '0, 1);
    push_exp("ng_turn", S_TURN, 9'(mturn), 1);
    tick();
    new_game = 1'b0; sw_move_valid = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    push_reset_vals(0);
    tick();

    // Commit X0, then assert reset asynchronously in the middle of an X1 request.
    do_req(1'b1, 4'd0, 1'b0, 4'd0, 2'b00, 1'b0);
    tick();
    sw_move_valid = 1'b1; sw_move_cell = 4'd1;
    #2;
    reset = 1'b0;
    model_reset();
    push_reset_vals(0);
    tick();
    sw_move_valid = 1'b0;
    push_reset_vals(0);
    tick();
    reset = 1'b1;
    tick();
    push_reset_vals(0);
    tick();

    // Row 0 win for X; O4 is followed by a request during CHECK.
    do_req(1'b1, 4'd0, 1'b0, 4'd0, 2'b00, 1'b0);
    do_req(1'b0, 4'd0, 1'b1, 4'd3, 2'b00, 1'b0);
    do_req(1'b1, 4'd1, 1'b0, 4'd0, 2'b00, 1'b0);
    do_req(1'b0, 4'd0, 1'b1, 4'd4, 2'b00, 1'b1);
    do_req(1'b1, 4'd2, 1'b0, 4'd0, 2'b00, 1'b0);
    push_exp("row_bx", S_BX, 9'h007, 0);
    push_exp("row_bo", S_BO, 9'h018, 0);
    push_exp("row_winner", S_WIN, 9'h001, 0);
    push_exp("row_line", S_LINE, 9'h007, 0);
    push_exp("row_state", S_STATE, 9'h002, 0);
    tick();
    do_req(1'b1, 4'd5, 1'b0, 4'd0, 2'b01, 1'b0);
    push_exp("done_line_held", S_LINE, 9'h007, 0);
    tick();

    // new_game beats a same-cycle move; start player alternates.
    do_new_game(1'b1);
    push_exp("ng1_turn", S_TURN, 9'd1, 0);
    tick();
    do_new_game(1'b0);
    push_exp("ng2_turn", S_TURN, 9'd0, 0);
    tick();

    // Occupied cell, then a legal O move.
    do_req(1'b1, 4'd4, 1'b0, 4'd0, 2'b00, 1'b0);
    do_req(1'b0, 4'd0, 1'b1, 4'd4, 2'b11, 1'b0);
    push_exp("occ_bo", S_BO, 9'h000, 0);
    push_exp("occ_turn", S_TURN, 9'd1, 0);
    tick();
    do_req(1'b0, 4'd0, 1'b1, 4'd0, 2'b00, 1'b0);

    // Bad requests on X's turn.
    do_req(1'b0, 4'd0, 1'b1, 4'd2, 2'b01, 1'b0);
    do_req(1'b1, 4'd9, 1'b0, 4'd0, 2'b10, 1'b0);
    do_req(1'b1, 4'd15, 1'b0, 4'd0, 2'b10, 1'b0);
    do_req(1'b1, 4'd5, 1'b1, 4'd6, 2'b00, 1'b0);
    push_exp("both_bx", S_BX, 9'h030, 0);
    push_exp("both_bo", S_BO, 9'h001, 0);
    tick();

    // Two new games bring X back to the start, then a full-board draw.
    do_new_game(1'b0);
    do_new_game(1'b0);
    do_req(1'b1, 4'd0, 1'b0, 4'd0, 2'b00, 1'b0);
    do_req(1'b0, 4'd0, 1'b1, 4'd1, 2'b00, 1'b0);
    do_req(1'b1, 4'd2, 1'b0, 4'd0, 2'b00, 1'b0);
    do_req(1'b0, 4'd0, 1'b1, 4'd4, 2'b00, 1'b0);
    do_req(1'b1, 4'd3, 1'b0, 4'd0, 2'b00, 1'b0);
    do_req(1'b0, 4'd0, 1'b1, 4'd5, 2'b00, 1'b0);
    do_req(1'b1, 4'd7, 1'b0, 4'd0, 2'b00, 1'b0);
    do_req(1'b0, 4'd0, 1'b1, 4'd6, 2'b00, 1'b0);
    do_req(1'b1, 4'd8, 1'b0, 4'd0, 2'b00, 1'b0);
    push_exp("draw_bx", S_BX, 9'h18D, 0);
    push_exp("draw_bo", S_BO, 9'h072, 0);
    push_exp("draw_winner", S_WIN, 9'h003, 0);
    push_exp("draw_line", S_LINE, 9'h000, 0);
    push_exp("draw_count", S_CNT, 9'd9, 0);
    push_exp("draw_state", S_STATE, 9'h002, 0);
    repeat (4) tick();

    check_val("sb_drain", 9'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
